// File: rtl/mux_arb_if.sv
// Stream bundle for mux_arb: N_CH valid/ready/last input channels, one registered output channel, plus sel.
// Valid/ready rule on every channel: a beat moves on a rising edge where valid and ready are both high; valid never waits on ready.
interface mux_arb_if #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_last;
  logic [N_CH-1:0]       in_ready;
  logic [CH_W-1:0]       sel;
  logic [WIDTH-1:0]      out_data;
  logic [CH_W-1:0]       out_ch;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data, in_valid, in_last, sel, out_ready,
    input  in_ready, out_data, out_ch, out_last, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, sel, out_ready,
    output in_ready, out_data, out_ch, out_last, out_valid
  );
endinterface

// File: rtl/mux_arb.sv
// Registered N-channel stream mux with round-robin / fixed-priority / external-select arbitration.
// A grant is held for a whole packet (until last); state_o is high while a packet is open.
module mux_arb #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4,
  parameter int MODE  = 0
) (
  input  logic     clk,
  input  logic     rst,
  mux_arb_if.slave bus,
  output logic     state_o
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CH_W-1:0]  lock_ch_q, lock_ch_d;
  logic [CH_W-1:0]  ptr_q, ptr_d;
  logic [CH_W-1:0]  grant_ch;
  logic             grant_any;
  logic             load, xfer;
  logic             beat_valid, beat_last;
  logic [WIDTH-1:0] beat_data;
  logic [WIDTH-1:0] out_data_q;
  logic [CH_W-1:0]  out_ch_q;
  logic             out_last_q, out_valid_q;

  assign load = !out_valid_q || bus.out_ready;

  // Loops run in reverse search order so the last hit is the winner.
  always_comb begin : arbiter
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_ch  = '0;
    if (state_q == LOCK) begin
      grant_any = 1'b1;
      grant_ch  = lock_ch_q;
    end else if (MODE == 0) begin
      for (int k = N_CH; k >= 1; k--) begin
        idx = (int'(ptr_q) + k) % N_CH;
        if (bus.in_valid[idx]) begin
          grant_any = 1'b1;
          grant_ch  = CH_W'(idx);
        end
      end
    end else if (MODE == 1) begin
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (bus.in_valid[i]) begin
          grant_any = 1'b1;
          grant_ch  = CH_W'(i);
        end
      end
    end else if (int'(bus.sel) < N_CH) begin
      for (int i = 0; i < N_CH; i++) begin
        if (bus.sel == CH_W'(i) && bus.in_valid[i]) begin
          grant_any = 1'b1;
          grant_ch  = CH_W'(i);
        end
      end
    end
  end

  always_comb begin : beat_mux
    beat_valid = 1'b0;
    beat_last  = 1'b0;
    beat_data  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant_ch == CH_W'(i)) begin
        beat_valid = bus.in_valid[i];
        beat_last  = bus.in_last[i];
        beat_data  = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer = !rst && grant_any && load && beat_valid;

  always_comb begin : ready_gen
    bus.in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      bus.in_ready[i] = !rst && grant_any && load && (grant_ch == CH_W'(i));
    end
  end

  always_comb begin : fsm_next
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    ptr_d     = ptr_q;
    if (xfer) begin
      ptr_d = grant_ch;
      if (state_q == ARB && !beat_last) begin
        state_d   = LOCK;
        lock_ch_d = grant_ch;
      end else if (state_q == LOCK && beat_last) begin
        state_d = ARB;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB;
      lock_ch_q   <= '0;
      ptr_q       <= CH_W'(N_CH - 1);
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
      ptr_q     <= ptr_d;
      if (load) begin
        out_valid_q <= xfer;
        if (xfer) begin
          out_data_q <= beat_data;
          out_ch_q   <= grant_ch;
          out_last_q <= beat_last;
        end
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_valid = out_valid_q;
  assign state_o       = (state_q == LOCK);
endmodule
